// File: rtl/firmc.sv
// Time-multiplexed multi-channel direct-form FIR filter.
// One shared multiplier performs one MAC per cycle; every channel keeps its own
// delay line while all channels share a single runtime-programmable coefficient bank.
// The accumulated sum is rounded, arithmetically shifted and saturated on output.
module firmc #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CW    = 16,
  parameter int unsigned N     = 8,
  parameter int unsigned CH    = 4,
  parameter int unsigned ACCW  = 40,
  parameter int unsigned OW    = 16,
  parameter int unsigned SHIFT = 14,
  parameter logic [CW*N-1:0] H = (CW*N)'(16'h4000),
  localparam int unsigned CHW  = (CH > 1) ? $clog2(CH) : 1,
  localparam int unsigned NW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [DW-1:0] x,
  input  logic                 coef_we,
  input  logic [NW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic signed [OW-1:0] y
);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  // Half-LSB rounding constant; evaluates to zero when SHIFT is zero.
  localparam logic signed [ACCW:0] Rnd  = ((ACCW + 1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACCW:0] OMax = (ACCW + 1)'({(OW - 1){1'b1}});
  localparam logic signed [ACCW:0] OMin = ~OMax;

  state_e state_q, state_d;

  logic signed [DW-1:0]   z_q [CH][N];
  logic signed [CW-1:0]   h_q [N];
  logic [CHW-1:0]         ch_q;
  logic [NW-1:0]          k_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [OW-1:0]   y_q;
  logic [CHW-1:0]         out_ch_q;
  logic                   out_valid_q;

  logic                   ch_ok;
  logic                   accept;
  logic                   last;
  logic                   coef_ok;
  logic                   coef_wr;
  logic signed [DW-1:0]   tap_x;
  logic signed [CW-1:0]   tap_h;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW:0]   rnd;
  logic signed [ACCW:0]   shr;
  logic signed [OW-1:0]   y_fmt;

  assign ch_ok   = 32'(in_ch) < CH;
  assign accept  = (state_q == StIdle) && in_valid && ch_ok && !clear;
  assign last    = (k_q == NW'(N - 1));
  assign coef_ok = 32'(coef_addr) < N;
  // Writes are dropped during MAC so a sum never mixes old and new coefficients;
  // a clear aborts the sum, so a write coinciding with it is still taken.
  assign coef_wr = coef_we && coef_ok && ((state_q != StMac) || clear);

  // Shared multiplier operands select the active channel's tap k.
  assign tap_x    = z_q[ch_q][k_q];
  assign tap_h    = h_q[k_q];
  assign prod     = tap_x * tap_h;
  assign prod_ext = ACCW'(prod);
  assign sum      = acc_q + prod_ext;

  // Round, shift and saturate the final sum (one extra bit keeps the rounding add exact).
  always_comb begin
    rnd = {sum[ACCW-1], sum} + Rnd;
    shr = rnd >>> SHIFT;
    if (shr > OMax) begin
      y_fmt = OMax[OW-1:0];
    end else if (shr < OMin) begin
      y_fmt = OMin[OW-1:0];
    end else begin
      y_fmt = shr[OW-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && ch_ok) begin
          state_d = StMac;
        end
      end
      StMac: begin
        if (last) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d = StIdle;
    end
  end

  // Per-channel delay lines; only the accepted channel ever shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int t = 0; t < N; t++) begin
          z_q[c][t] <= '0;
        end
      end
    end else if (clear) begin
      for (int c = 0; c < CH; c++) begin
        for (int t = 0; t < N; t++) begin
          z_q[c][t] <= '0;
        end
      end
    end else if (accept) begin
      for (int c = 0; c < CH; c++) begin
        if (CHW'(c) == in_ch) begin
          for (int t = N - 1; t > 0; t--) begin
            z_q[c][t] <= z_q[c][t-1];
          end
          z_q[c][0] <= x;
        end
      end
    end
  end

  // Shared coefficient bank; clear leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < N; t++) begin
        h_q[t] <= H[t*CW +: CW];
      end
    end else if (coef_wr) begin
      for (int t = 0; t < N; t++) begin
        if (NW'(t) == coef_addr) begin
          h_q[t] <= coef_data;
        end
      end
    end
  end

  // MAC sequencing and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      k_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            ch_q  <= in_ch;
            k_q   <= '0;
            acc_q <= '0;
          end
        end
        StMac: begin
          acc_q <= sum;
          if (last) begin
            k_q         <= '0;
            y_q         <= y_fmt;
            out_ch_q    <= ch_q;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + NW'(1);
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign y         = y_q;

endmodule

// File: tb/tb_firmc.sv
// Self-checking bench for firmc: directed test-plan steps plus a randomized phase,
// checked against an arithmetic reference model of the filter.
module tb_firmc;

  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int N     = 8;
  localparam int CH    = 4;
  localparam int ACCW  = 40;
  localparam int OW    = 16;
  localparam int SHIFT = 14;
  localparam int CHW   = 2;
  localparam int NW    = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [CHW-1:0]       in_ch;
  logic signed [DW-1:0] x;
  logic                 coef_we = 1'b0;
  logic [NW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [CHW-1:0]       out_ch;
  logic signed [OW-1:0] y;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: sample history per channel and the coefficient bank.
  int hist [CH][N];
  int hm [N];

  always #5 clk = ~clk;

  firmc #(
    .DW(DW), .CW(CW), .N(N), .CH(CH), .ACCW(ACCW), .OW(OW), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .x(x),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .y(y)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < N; k++) hist[c][k] = 0;
    end
    for (int k = 0; k < N; k++) hm[k] = (k == 0) ? 16384 : 0;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < N; k++) hist[c][k] = 0;
    end
  endfunction

  function automatic void model_push(input int c, input int v);
    for (int k = N - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
    hist[c][0] = v;
  endfunction

  // Dot product, wrapped to ACCW bits, then round-half-up, floor shift and clamp.
  function automatic int model_out(input int c);
    longint acc;
    longint lim;
    acc = 0;
    for (int k = 0; k < N; k++) acc += longint'(hist[c][k]) * longint'(hm[k]);
    acc = (acc <<< (64 - ACCW)) >>> (64 - ACCW);
    if (SHIFT > 0) acc = acc + (longint'(1) <<< (SHIFT - 1));
    acc = acc >>> SHIFT;
    lim = longint'(1) <<< (OW - 1);
    if (acc > lim - 1) acc = lim - 1;
    if (acc < -lim) acc = -lim;
    return int'(acc);
  endfunction

  task automatic wr_coef(input int a, input int v);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = NW'(a);
    coef_data = CW'(v);
    @(negedge clk);
    coef_we = 1'b0;
    if (a < N) hm[a] = int'($signed(CW'(v)));
  endtask

  // Send one sample, check latency, backpressure stability and the result.
  task automatic send(input int c, input int xv, input int hold, input bit mac_wr,
                      output int got);
    int expy;
    int cyc;
    logic signed [OW-1:0] y0;
    logic [CHW-1:0] ch0;
    model_push(c, xv);
    expy = model_out(c);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_ch    = CHW'(c);
    x        = DW'(xv);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_mac", busy, 1);
    check("in_ready_mac", in_ready, 0);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < N + 8) begin
      coef_we   = mac_wr && (cyc == 2);
      coef_addr = '0;
      coef_data = 16'sh1234;
      @(negedge clk);
      cyc++;
    end
    coef_we = 1'b0;
    check("latency", cyc, N);
    check("out_valid_up", out_valid, 1);
    check("y", y, expy);
    check("out_ch", out_ch, c);
    y0  = y;
    ch0 = out_ch;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_y", y, y0);
      check("hold_ch", out_ch, ch0);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_down", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    got = int'(y0);
  endtask

  initial begin
    int got;
    int cyc;
    bit seen;
    model_reset();
    in_ch     = '0;
    x         = '0;
    coef_addr = '0;
    coef_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // 1: default impulse coefficients
    send(0, 1000, 0, 0, got);
    check("tp1_y1000", got, 1000);
    send(0, -5, 0, 0, got);
    check("tp1_y_neg5", got, -5);

    // 2: all taps 1.0, running sums with an interleaved channel
    for (int k = 0; k < N; k++) wr_coef(k, 16'h4000);
    send(1, 100, 0, 0, got);
    check("tp2_ch1_100", got, 100);
    send(2, 7, 0, 0, got);
    check("tp2_ch2_7", got, 7);
    send(1, 200, 1, 0, got);
    check("tp2_ch1_300", got, 300);
    send(1, 300, 0, 0, got);
    check("tp2_ch1_600", got, 600);

    // 3: saturation both ways
    for (int k = 0; k < N; k++) wr_coef(k, 16'h7FFF);
    for (int i = 0; i < N; i++) send(0, 32767, 0, 0, got);
    check("tp3_sat_pos", got, 32767);
    for (int i = 0; i < N; i++) send(0, -32768, 0, 0, got);
    check("tp3_sat_neg", got, -32768);

    // 4: rounding with tap0 = 0.5
    wr_coef(0, 16'h2000);
    for (int k = 1; k < N; k++) wr_coef(k, 0);
    send(0, 3, 0, 0, got);
    check("tp4_round_3", got, 2);
    send(0, -3, 0, 0, got);
    check("tp4_round_m3", got, -1);
    send(0, 1, 0, 0, got);
    check("tp4_round_1", got, 1);

    // 5: backpressure and a coefficient write dropped during MAC
    send(2, 12345, 5, 1, got);
    check("tp5_bp_y", got, 6173);
    send(2, 100, 0, 0, got);
    check("tp5_coef_kept", got, 50);

    // Randomized phase
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        wr_coef(int'($urandom_range(0, N - 1)), int'($signed(16'($urandom))));
      end
      send(int'($urandom_range(0, CH - 1)), int'($signed(16'($urandom))),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
    end

    // 6a: clear mid-MAC aborts the sum and wipes history
    wr_coef(0, 16'h4000);
    for (int k = 1; k < N; k++) wr_coef(k, 16'h4000);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = '0;
    x        = 16'sd1234;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    seen = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    check("clear_no_valid", seen, 0);
    check("clear_idle", busy, 0);
    send(0, 50, 0, 0, got);
    check("clear_zero_hist", got, 50);

    // 6b: async reset while holding a result
    wr_coef(0, 16'h2000);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'd1;
    x        = 16'sd400;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < N + 8) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_pre_valid", out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_y", y, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send(3, 777, 0, 0, got);
    check("rst_coef_revert", got, 777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/firmc.md
Name: firmc

Overview:
- Multi-channel, time-multiplexed direct-form FIR filter with runtime-programmable coefficients.
- Uses one shared multiplier and performs one MAC per cycle. Each channel has its own delay line; all channels share one coefficient bank.
- Input and output use valid/ready handshakes. Output is rounded, shifted and saturated.
- Used in the fixed-point DSP chain where several low-rate channels share one filter datapath.

Parameters:
- DW, 16: input sample width (signed).
- CW, 16: coefficient width (signed).
- N, 8: taps per channel (N >= 2).
- CH, 4: number of channels (CH >= 1).
- ACCW, 40: accumulator width; products are sign-extended to ACCW.
- OW, 16: output width (signed).
- SHIFT, 14: right shift applied to the accumulator before saturation.
- H, tap0 = 16'h4000 (1.0 in Q14), others 0: reset value of the coefficient bank, [CW*N-1:0], tap k at H[k*CW+:CW].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of delay lines and operation in progress.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input ready; high only in IDLE.
- in_ch  in  max(1,$clog2(CH))  channel of the input sample.
- x  in  DW  input sample, signed.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  max(1,$clog2(N))  tap index to write.
- coef_data  in  CW  coefficient value, signed.
- busy  out  1  high when state is not IDLE.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.
- out_ch  out  max(1,$clog2(CH))  channel of y.
- y  out  OW  filtered sample, signed.

Behaviour:
- States: IDLE, MAC, OUT.
- rst (async): state goes to IDLE; all delay lines = 0; coefficient bank = H; out_valid = 0; y = 0; out_ch = 0; accumulator and tap counter = 0.
- clear (sync, takes priority over all other inputs):
  - Zeroes all delay lines.
  - Aborts any MAC/OUT; state goes to IDLE; out_valid = 0.
  - Coefficients are kept. A coef_we in the same cycle is still applied.
- IDLE: in_ready = 1. When in_valid is high:
  - If in_ch >= CH, the sample is consumed and discarded, with no output.
  - Otherwise, shift the channel's delay line (z[k] <= z[k-1], z[0] <= x), latch the channel, set acc = 0 and k = 0, and go to MAC.
- MAC: one cycle per tap, k = 0..N-1, with acc <= acc + z[ch][k]*h[k].
  - The sample just accepted counts as tap 0 (current-sample output).
  - acc wraps modulo 2^ACCW.
  - On the cycle with k = N-1, the final sum is formatted into y, out_ch is loaded, out_valid is set to 1, and state goes to OUT.
- Latency: out_valid rises N edges after the accepting edge.
- OUT: y and out_ch are held stable while out_valid=1 and out_ready=0. The handshake completes on out_valid & out_ready; out_valid then drops and state returns to IDLE.
- Peak throughput: one sample every N+2 cycles.
- Output format:
  - r = acc + 2^(SHIFT-1). No rounding term is added when SHIFT = 0.
  - Arithmetic right shift by SHIFT.
  - Saturate to [-2^(OW-1), 2^(OW-1)-1].
- Coefficient writes:
  - Applied on coef_we in IDLE or OUT.
  - Ignored (dropped) in MAC, so coefficients never change mid-sum.
  - coef_addr >= N is ignored.
- The delay lines of channels other than the active one are never modified.

Test Plan:
1. Default coefficients after rst: ch0 x=1000 → after N cycles out_valid=1, y=1000, out_ch=0. Then ch0 x=-5 → y=-5 (pure impulse).
2. Write all taps = 16'h4000, then send:
   - ch1: 100, 200, 300 → y = 100, 300, 600.
   - ch2: 7, interleaved between the ch1 samples → y = 7, and ch1 results are unchanged (channel isolation).
3. Saturation: all taps = 16'h7FFF; ch0 fed 32767 eight times → final y = 32767. Then -32768 repeated eight times → y = -32768.
4. Rounding: tap0 = 16'h2000, other taps 0.
   - x=3 → acc=24576, y=2.
   - x=-3 → y=-1.
   - x=1 → y=1 (acc=8192 rounds up).
5. Backpressure: hold out_ready=0 for 5 cycles → out_valid, y and out_ch stay stable and in_ready=0. Also issue coef_we to tap0 during MAC → the result is unaffected and the coefficient is unchanged on the next sample.
6. clear at MAC cycle 3 → out_valid never rises; the next ch0 x=50 gives y=50 with zero history. Assert rst mid-OUT → out_valid drops immediately and coefficients revert to H.
